// File: rtl/program_loader.sv
// program_loader: frames a host byte stream into instruction words and holds the CPU in reset until the image verifies
// Ports:
//   clk, reset           rising-edge clock, synchronous active-low reset
//   rx_valid, rx_byte    offered stream byte; a transfer happens when rx_valid & rx_ready
//   reload               restart loading from DONE or ERR
//   rx_ready             loader accepts a byte (registered)
//   imem_we/addr/wdata   one-cycle instruction-memory write per assembled word
//   cpu_reset            CPU held in reset until the image is verified
//   done, error          image verified / framing or checksum failure (sticky)
module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              reload,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHECK, DONE, ERR} state_t;
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;
    state_t state;
    logic [7:0] cnt_hi;
    logic [15:0] cnt;
    logic [1:0] idx;
    logic [ADDR_W:0] wcnt;
    logic [23:0] shreg;
    logic [7:0] chk;
    logic xfer;
    logic [16:0] n_new;
    logic last_word;
    assign xfer = rx_valid & rx_ready;
    assign n_new = {1'b0, cnt_hi, rx_byte};
    // word counter is one bit wider than the address so a full 2^ADDR_W image can be counted
    assign last_word = (17'(wcnt) + 17'd1) == {1'b0, cnt};
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HDR_HI;
            rx_ready <= 1'b0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            cpu_reset <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
            cnt_hi <= '0;
            cnt <= '0;
            idx <= '0;
            wcnt <= '0;
            shreg <= '0;
            chk <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    rx_ready <= 1'b1;
                    if (xfer) begin
                        cnt_hi <= rx_byte;
                        state <= HDR_LO;
                    end
                end
                HDR_LO: if (xfer) begin
                    cnt <= n_new[15:0];
                    if (n_new == 17'd0) begin
                        state <= CHECK;
                    end else if (n_new > CAP) begin
                        state <= ERR;
                        rx_ready <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (xfer) begin
                    shreg <= {shreg[15:0], rx_byte};
                    chk <= chk ^ rx_byte;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        imem_we <= 1'b1;
                        imem_wdata <= {shreg, rx_byte};
                        imem_addr <= wcnt[ADDR_W-1:0];
                        wcnt <= wcnt + 1'b1;
                        if (last_word) state <= CHECK;
                    end
                end
                CHECK: if (xfer) begin
                    rx_ready <= 1'b0;
                    if (rx_byte == chk) begin
                        state <= DONE;
                        done <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state <= ERR;
                        error <= 1'b1;
                    end
                end
                DONE, ERR: if (reload) begin
                    state <= HDR_HI;
                    rx_ready <= 1'b1;
                    cpu_reset <= 1'b1;
                    done <= 1'b0;
                    error <= 1'b0;
                    cnt_hi <= '0;
                    cnt <= '0;
                    idx <= '0;
                    wcnt <= '0;
                    shreg <= '0;
                    chk <= '0;
                end
                default: state <= HDR_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized stream loads checked against a frame-level reference model
module tb_program_loader;
    typedef logic [7:0] bq_t[$];
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_valid = 1'b0;
    logic reload = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic r10, we10, cr10, d10, e10;
    logic [9:0] a10;
    logic [31:0] w10;
    logic r4, we4, cr4, d4, e4;
    logic [3:0] a4;
    logic [31:0] w4;
    logic sel = 1'b0;
    logic chk_en = 1'b0;
    logic c_ready, c_we, c_cpu_reset, c_done, c_err;
    logic [9:0] c_addr;
    logic [31:0] c_data;
    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    logic [31:0] exp_data[$];
    int pa;
    logic [31:0] pd;

    program_loader #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .reload(reload),
        .rx_ready(r10), .imem_we(we10), .imem_addr(a10), .imem_wdata(w10),
        .cpu_reset(cr10), .done(d10), .error(e10)
    );
    program_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .reload(reload),
        .rx_ready(r4), .imem_we(we4), .imem_addr(a4), .imem_wdata(w4),
        .cpu_reset(cr4), .done(d4), .error(e4)
    );

    always #5 clk = ~clk;

    always_comb begin
        c_ready = sel ? r4 : r10;
        c_we = sel ? we4 : we10;
        c_addr = sel ? 10'(a4) : a10;
        c_data = sel ? w4 : w10;
        c_cpu_reset = sel ? cr4 : cr10;
        c_done = sel ? d4 : d10;
        c_err = sel ? e4 : e10;
    end

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        if (c_we) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h with no write expected", c_addr, c_data);
            end else begin
                pa = exp_addr.pop_front();
                pd = exp_data.pop_front();
                expect_eq("wr_addr", 32'(c_addr), 32'(pa));
                expect_eq("wr_data", c_data, pd);
            end
        end
        expect_eq("cpu_reset_vs_done", 32'(c_cpu_reset), 32'(!c_done));
        expect_eq("done_and_error", 32'(c_done & c_err), 32'd0);
    end

    function automatic bq_t make_frame(input int n, input bit good);
        bq_t q;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n <= 1024) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom_range(0, 255));
                x ^= b;
                q.push_back(b);
            end
        end
        q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
        return q;
    endfunction

    task automatic expect_frame(input bq_t q, input int cap, output bit ok, output int used);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        n = int'({q[0], q[1]});
        x = 8'h00;
        if (n > cap) begin
            ok = 1'b0;
            used = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = {q[2 + 4 * i], q[3 + 4 * i], q[4 + 4 * i], q[5 + 4 * i]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            exp_addr.push_back(i);
            exp_data.push_back(w);
        end
        used = 3 + 4 * n;
        ok = (q[used - 1] == x);
    endtask

    task automatic send(input bq_t q, input int count, input int mode);
        int i = 0;
        int budget = 0;
        bit take;
        bit tog = 1'b1;
        while (i < count) begin
            rx_byte = q[i];
            rx_valid = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            @(negedge clk);
            take = rx_valid && c_ready;
            @(posedge clk);
            #1;
            if (take) i++;
            budget++;
            if (budget > 20 * count + 50) begin
                expect_eq("send_timeout", 32'(i), 32'(count));
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic finish_frame(input bit ok);
        int n = 0;
        while (!(c_done || c_err) && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        expect_eq("done", 32'(c_done), 32'(ok));
        expect_eq("error", 32'(c_err), 32'(!ok));
        expect_eq("cpu_reset", 32'(c_cpu_reset), 32'(!ok));
        rx_valid = 1'b1;
        rx_byte = 8'h5A;
        repeat (4) begin
            @(negedge clk);
            expect_eq("rx_ready_idle", 32'(c_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        expect_eq("done_held", 32'(c_done), 32'(ok));
        expect_eq("writes_pending", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic run_frame(input bq_t q, input int mode);
        bit ok;
        int used;
        expect_frame(q, sel ? 16 : 1024, ok, used);
        send(q, used, mode);
        finish_frame(ok);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        expect_eq("reload_error", 32'(c_err), 32'd0);
        expect_eq("reload_done", 32'(c_done), 32'd0);
        expect_eq("reload_cpu_reset", 32'(c_cpu_reset), 32'd1);
        expect_eq("reload_rx_ready", 32'(c_ready), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        expect_eq("rst_rx_ready", 32'(c_ready), 32'd0);
        expect_eq("rst_imem_we", 32'(c_we), 32'd0);
        expect_eq("rst_imem_addr", 32'(c_addr), 32'd0);
        expect_eq("rst_imem_wdata", c_data, 32'd0);
        expect_eq("rst_cpu_reset", 32'(c_cpu_reset), 32'd1);
        expect_eq("rst_done", 32'(c_done), 32'd0);
        expect_eq("rst_error", 32'(c_err), 32'd0);
        reset = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        chk_en = 1'b1;
    endtask

    initial begin
        bq_t normal;
        bq_t bad;
        bit ok;
        int used;
        normal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04, 8'h84};
        bad = normal;
        bad[10] = 8'h00;
        do_reset();
        expect_frame(normal, 1024, ok, used);
        expect_eq("model_ok", 32'(ok), 32'd1);
        expect_eq("model_used", 32'(used), 32'd11);
        expect_eq("model_w0", exp_data[0], 32'h20080005);
        expect_eq("model_w1", exp_data[1], 32'hAC010004);
        send(normal, used, 0);
        finish_frame(ok);
        do_reload();
        expect_frame(bad, 1024, ok, used);
        expect_eq("model_bad_chk", 32'(ok), 32'd0);
        send(bad, used, 0);
        finish_frame(ok);
        do_reload();
        run_frame(make_frame(0, 1'b1), 0);
        do_reload();
        run_frame(normal, 1);
        do_reload();
        exp_addr.push_back(0);
        exp_data.push_back(32'h20080005);
        send(normal, 6, 0);
        do_reset();
        run_frame(normal, 0);
        do_reload();
        for (int k = 0; k < 20; k++) begin
            int n;
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) n = 1025;
            run_frame(make_frame(n, 1'($urandom_range(0, 1))), $urandom_range(0, 2));
            do_reload();
        end
        run_frame(make_frame(1024, 1'b1), 0);
        sel = 1'b1;
        do_reset();
        run_frame(make_frame(17, 1'b1), 2);
        do_reload();
        run_frame(make_frame(16, 1'b1), 2);
        do_reload();
        run_frame(make_frame(16, 1'b0), 1);
        do_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
